// File: rtl/audio_seq_pkg.sv
// Shared constants for the audio stream sequencer: state encoding, default sample width, channel slices.
// The optional statistics counters are enabled by defining AUDIO_SEQ_STATS_EN.
package audio_seq_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int CH_WIDTH       = 16;
    localparam int LEFT_LSB       = 0;
    localparam int RIGHT_LSB      = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READ    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_PROC    = 3'd3;
    localparam logic [2:0] ST_WRITE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_READ    = ST_READ,
        S_CAPTURE = ST_CAPTURE,
        S_PROC    = ST_PROC,
        S_WRITE   = ST_WRITE
    } seq_state_e;

endpackage

// File: rtl/audio_stream_sequencer_if.sv
// Handshake bundle between the sequencer and the RX FIFO, processing chain and TX FIFO.
// master = sequencer side, slave = FIFO / processing side.
interface audio_stream_sequencer_if #(
    parameter int DATA_WIDTH = audio_seq_pkg::DEF_DATA_WIDTH
);
    logic                  adcfifo_empty;
    logic                  adcfifo_read;
    logic [DATA_WIDTH-1:0] adcfifo_readdata;
    logic                  proc_start;
    logic [DATA_WIDTH-1:0] proc_data;
    logic                  proc_done;
    logic [DATA_WIDTH-1:0] proc_result;
    logic                  dacfifo_full;
    logic                  dacfifo_write;
    logic [DATA_WIDTH-1:0] dacfifo_writedata;

    modport master (
        input  adcfifo_empty, adcfifo_readdata, proc_done, proc_result, dacfifo_full,
        output adcfifo_read, proc_start, proc_data, dacfifo_write, dacfifo_writedata
    );

    modport slave (
        output adcfifo_empty, adcfifo_readdata, proc_done, proc_result, dacfifo_full,
        input  adcfifo_read, proc_start, proc_data, dacfifo_write, dacfifo_writedata
    );
endinterface

// File: rtl/audio_stream_sequencer_timeout.sv
// Processing timeout counter: synchronous clear, count enable, terminal-count flag.
// tc marks the PROC cycle whose increment brings the count to TIMEOUT_CYCLES.
module seq_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/audio_stream_sequencer.sv
// One-sample-at-a-time sequencer: RX FIFO -> processing chain (or bypass) -> TX FIFO.
// Define AUDIO_SEQ_STATS_EN to add saturating sample/timeout/stall counters.
module audio_stream_sequencer
    import audio_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
`ifdef AUDIO_SEQ_STATS_EN
    , parameter int CNT_WIDTH    = 16
`endif
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        bypass,
    audio_stream_sequencer_if.master    bus,
    output logic                        busy,
    output logic                        timeout_err
`ifdef AUDIO_SEQ_STATS_EN
    , output logic [CNT_WIDTH-1:0]      sample_cnt
    , output logic [CNT_WIDTH-1:0]      timeout_cnt
    , output logic [CNT_WIDTH-1:0]      stall_cnt
`endif
);

    seq_state_e            state, state_nx;
    logic [DATA_WIDTH-1:0] sample_q, result_q;
    logic                  proc_start_q, timeout_err_q;
    logic                  to_tc;

    seq_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state == S_CAPTURE),
        .en      (state == S_PROC),
        .tc      (to_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            sample_q      <= '0;
            result_q      <= '0;
            proc_start_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state        <= state_nx;
            // Registered so proc_start lines up with the already-registered proc_data.
            proc_start_q <= (state == S_CAPTURE) && !bypass;
            if (state == S_CAPTURE) begin
                sample_q <= bus.adcfifo_readdata;
                if (bypass) result_q <= bus.adcfifo_readdata;
            end
            if (state == S_PROC) begin
                if (bus.proc_done) begin
                    result_q <= bus.proc_result;
                end else if (to_tc) begin
                    result_q      <= sample_q;
                    timeout_err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (enable && !bus.adcfifo_empty) state_nx = S_READ;
            S_READ:    state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = bypass ? S_WRITE : S_PROC;
            S_PROC:    if (bus.proc_done || to_tc) state_nx = S_WRITE;
            S_WRITE:   if (!bus.dacfifo_full) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    assign bus.adcfifo_read      = (state == S_READ);
    assign bus.proc_start        = proc_start_q;
    assign bus.proc_data         = sample_q;
    assign bus.dacfifo_write     = (state == S_WRITE) && !bus.dacfifo_full;
    assign bus.dacfifo_writedata = result_q;
    assign busy                  = (state != S_IDLE);
    assign timeout_err           = timeout_err_q;

`ifdef AUDIO_SEQ_STATS_EN
    // A timeout only counts when proc_done did not arrive in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_cnt  <= '0;
            timeout_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (bus.dacfifo_write && !(&sample_cnt))
                sample_cnt <= sample_cnt + CNT_WIDTH'(1);
            if ((state == S_PROC) && to_tc && !bus.proc_done && !(&timeout_cnt))
                timeout_cnt <= timeout_cnt + CNT_WIDTH'(1);
            if ((state == S_WRITE) && bus.dacfifo_full && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Self-checking bench for audio_stream_sequencer: vector table plus hand-written corner sequences.
// Checks statistics counters too when AUDIO_SEQ_STATS_EN is defined.
module tb_audio_stream_sequencer;
    import audio_seq_pkg::*;

    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic bypass = 1'b0;
    logic busy, timeout_err;
`ifdef AUDIO_SEQ_STATS_EN
    logic [15:0] sample_cnt, timeout_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    audio_stream_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    audio_stream_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .bypass      (bypass),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
`ifdef AUDIO_SEQ_STATS_EN
        , .sample_cnt  (sample_cnt)
        , .timeout_cnt (timeout_cnt)
        , .stall_cnt   (stall_cnt)
`endif
    );

    int checks = 0, errors = 0;
    int cyc = 0, rd_count = 0, wr_count = 0, rd_cyc = 0, wr_cyc = 0, viol = 0;
    logic [31:0] rx_q[$];
    logic [31:0] exp_q[$];
    int proc_delay = 0, pcnt = 0;
    bit pending = 0, orphan = 0;
    logic [31:0] pdata = '0;

    typedef struct {
        bit          byp;
        logic [31:0] din;
        int          dly;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[6];

    // Processing chain stand-in: doubles each channel, wrapping within 16 bits.
    function automatic logic [31:0] proc_fn(input logic [31:0] s);
        logic [CH_WIDTH-1:0] l, r;
        l = s[LEFT_LSB +: CH_WIDTH];
        r = s[RIGHT_LSB +: CH_WIDTH];
        l = l << 1;
        r = r << 1;
        return {r, l};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO / processing models and monitors, all acting on the falling edge.
    always @(negedge clk) begin
        if (!reset_n && pending) orphan = 1;
        if (bus.adcfifo_read && bus.dacfifo_write) viol++;
        if ((bus.adcfifo_read || bus.dacfifo_write || bus.proc_start) && !busy) viol++;
        if (bus.proc_start && pending) viol++;
        if (pending && !orphan && bus.proc_data !== pdata) viol++;
        if (bus.dacfifo_write) begin
            wr_count++;
            wr_cyc = cyc;
            if (exp_q.size() == 0) chk("tx_unexpected_write", bus.dacfifo_writedata, 32'hxxxx_xxxx);
            else chk("tx_data", bus.dacfifo_writedata, exp_q.pop_front());
        end
        if (bus.adcfifo_read) begin
            rd_count++;
            rd_cyc = cyc;
            if (rx_q.size() > 0) bus.adcfifo_readdata = rx_q.pop_front();
            else viol++;
        end
        bus.adcfifo_empty = (rx_q.size() == 0);
        bus.proc_done = 1'b0;
        if (pending) begin
            pcnt--;
            if (pcnt == 0) begin
                bus.proc_done   = 1'b1;
                bus.proc_result = proc_fn(pdata);
                pending = 0;
                orphan  = 0;
            end
        end
        if (bus.proc_start && proc_delay >= 0) begin
            pdata = bus.proc_data;
            if (proc_delay == 0) begin
                bus.proc_done   = 1'b1;
                bus.proc_result = proc_fn(pdata);
            end else begin
                pending = 1;
                pcnt    = proc_delay;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] e);
        rx_q.push_back(d);
        exp_q.push_back(e);
    endtask

    task automatic wait_wr(input int n0, input string name);
        int b = 0;
        while (wr_count == n0 && b < 60) begin step(); b++; end
        if (wr_count == n0) begin
            checks++; errors++;
            $display("FAIL %s: write count %0d after 60 cycles, expected %0d", name, wr_count, n0 + 1);
        end
    endtask

    task automatic wait_rd(input int r0, input string name);
        int b = 0;
        while (rd_count == r0 && b < 60) begin step(); b++; end
        if (rd_count == r0) begin
            checks++; errors++;
            $display("FAIL %s: read count %0d after 60 cycles, expected %0d", name, rd_count, r0 + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int n0, r0;
        vecs[0] = '{1'b1, 32'h1234_ABCD, 0, 32'h1234_ABCD, 2};
        vecs[1] = '{1'b0, 32'h0001_0002, 5, 32'h0002_0004, 8};
        vecs[2] = '{1'b0, 32'h7FFF_8001, 0, 32'hFFFE_0002, 3};
        vecs[3] = '{1'b0, 32'hA5A5_5A5A, 1, 32'h4B4A_B4B4, 4};
        vecs[4] = '{1'b1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 2};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 2, 32'hFFFE_FFFE, 5};

        bus.adcfifo_empty = 1'b1;
        bus.adcfifo_readdata = '0;
        bus.proc_done = 1'b0;
        bus.proc_result = '0;
        bus.dacfifo_full = 1'b0;

        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_adcfifo_read", bus.adcfifo_read, 0);
        chk("rst_proc_start", bus.proc_start, 0);
        chk("rst_proc_data", bus.proc_data, 0);
        chk("rst_dacfifo_write", bus.dacfifo_write, 0);
        chk("rst_dacfifo_writedata", bus.dacfifo_writedata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset_n = 1'b1;
        step();
        chk("idle_empty_busy", busy, 0);
        enable = 1'b1;

        for (int i = 0; i < 6; i++) begin
            bypass = vecs[i].byp;
            proc_delay = vecs[i].dly;
            n0 = wr_count;
            push(vecs[i].din, vecs[i].exp);
            wait_wr(n0, $sformatf("vec%0d_write", i));
            chk($sformatf("vec%0d_latency", i), wr_cyc - rd_cyc, vecs[i].lat);
            chk($sformatf("vec%0d_timeout_err", i), timeout_err, 0);
            repeat (2) step();
        end

        // Processing never answers: raw sample goes out after the timeout.
        bypass = 1'b0;
        proc_delay = -1;
        n0 = wr_count;
        push(32'h0BAD_F00D, 32'h0BAD_F00D);
        wait_wr(n0, "timeout_write");
        chk("timeout_latency", wr_cyc - rd_cyc, TO + 2);
        chk("timeout_err_set", timeout_err, 1);
        proc_delay = 2;
        n0 = wr_count;
        push(32'h0003_0004, 32'h0006_0008);
        wait_wr(n0, "post_timeout_write");
        chk("post_timeout_latency", wr_cyc - rd_cyc, 5);
        chk("timeout_err_sticky", timeout_err, 1);
`ifdef AUDIO_SEQ_STATS_EN
        chk("timeout_cnt", timeout_cnt, 1);
`endif
        repeat (2) step();

        // TX full for 10 cycles while in WRITE, with another sample waiting.
        bypass = 1'b1;
        bus.dacfifo_full = 1'b1;
        n0 = wr_count;
        r0 = rd_count;
`ifdef AUDIO_SEQ_STATS_EN
        chk("stall_cnt_before", stall_cnt, 0);
`endif
        push(32'hCAFE_0001, 32'hCAFE_0001);
        repeat (3) step();
        push(32'hCAFE_0002, 32'hCAFE_0002);
        repeat (10) step();
        chk("stall_no_read", rd_count, r0 + 1);
        chk("stall_no_write", wr_count, n0);
`ifdef AUDIO_SEQ_STATS_EN
        chk("stall_cnt", stall_cnt, 10);
`endif
        bus.dacfifo_full = 1'b0;
        wait_wr(n0, "stall_release_write");
        step();
        chk("stall_single_write", wr_count, n0 + 1);
        wait_wr(n0 + 1, "stall_next_write");
        chk("stall_next_latency", wr_cyc - rd_cyc, 2);
        repeat (2) step();

        // enable dropped right after the read: sample completes, then no more reads.
        bypass = 1'b0;
        proc_delay = 3;
        n0 = wr_count;
        r0 = rd_count;
        push(32'h0010_0020, 32'h0020_0040);
        push(32'h1111_2222, 32'h2222_4444);
        wait_rd(r0, "enable_first_read");
        enable = 1'b0;
        wait_wr(n0, "enable_drop_write");
        repeat (20) step();
        chk("enable_low_reads", rd_count, r0 + 1);
        chk("enable_low_writes", wr_count, n0 + 1);
        chk("enable_low_rx_left", rx_q.size(), 1);
        chk("enable_low_busy", busy, 0);
        enable = 1'b1;
        wait_wr(n0 + 1, "enable_resume_write");
        repeat (2) step();

        // Reset during PROC: in-flight sample dropped, late proc_done ignored.
        proc_delay = 6;
        n0 = wr_count;
        r0 = rd_count;
        push(32'h1234_5678, 32'h2468_ACF0);
        wait_rd(r0, "reset_read");
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_adcfifo_read", bus.adcfifo_read, 0);
        chk("midrst_proc_start", bus.proc_start, 0);
        chk("midrst_proc_data", bus.proc_data, 0);
        chk("midrst_dacfifo_write", bus.dacfifo_write, 0);
        chk("midrst_dacfifo_writedata", bus.dacfifo_writedata, 0);
        chk("midrst_timeout_err", timeout_err, 0);
`ifdef AUDIO_SEQ_STATS_EN
        chk("midrst_sample_cnt", sample_cnt, 0);
`endif
        exp_q.delete();
        repeat (2) step();
        reset_n = 1'b1;
        repeat (12) step();
        chk("postrst_no_write", wr_count, n0);
        chk("postrst_busy", busy, 0);

        chk("protocol_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_stream_sequencer.md
Name: audio_stream_sequencer

Overview:
- Sequences one stereo sample at a time from the I2S receive FIFO, through the echo/low-pass processing chain, into the I2S transmit FIFO.
- Replaces ad-hoc free-running read/write strobes with an explicit, non-overlapping handshake.
- Sits between i2s_rx, the processing chain (echo plus filter_lowpass per channel) and i2s_tx, all on the system clock.
- Provides processing bypass, a processing-timeout fallback and error flags.

Parameters:
- DATA_WIDTH, 32, packed stereo sample width: [15:0] left, [31:16] right.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for proc_done after proc_start.
- CNT_WIDTH, 16, width of the optional statistics counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run sequencer; when low, finish the current sample, then idle.
- bypass  in  1  route the ADC sample straight to the DAC, skipping processing.
- adcfifo_empty  in  1  RX FIFO empty.
- adcfifo_read  out  1  RX FIFO read strobe, one-cycle pulse.
- adcfifo_readdata  in  DATA_WIDTH  RX FIFO data, valid the cycle after the read strobe.
- proc_start  out  1  one-cycle pulse to the processing chain.
- proc_data  out  DATA_WIDTH  sample to process; held stable from proc_start until proc_done.
- proc_done  in  1  processing result valid (one-cycle pulse).
- proc_result  in  DATA_WIDTH  processed sample.
- dacfifo_full  in  1  TX FIFO full.
- dacfifo_write  out  1  TX FIFO write strobe, one-cycle pulse.
- dacfifo_writedata  out  DATA_WIDTH  TX FIFO data; registered, valid with the write strobe.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on a processing timeout; cleared only by reset.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset asserted mid-operation discards the in-flight sample.
- States: IDLE, READ, CAPTURE, PROC, WRITE.
- IDLE -> READ when enable=1 and adcfifo_empty=0.
- READ: adcfifo_read=1 for exactly one cycle -> CAPTURE.
- CAPTURE: register adcfifo_readdata into the sample register.
  - bypass=1: result register = sample -> WRITE.
  - bypass=0: proc_data = sample, proc_start=1 for one cycle -> PROC.
- PROC: timeout counter increments each cycle.
  - proc_done=1: result register = proc_result -> WRITE.
  - Counter reaches TIMEOUT_CYCLES without proc_done: result = raw sample, timeout_err set -> WRITE.
  - proc_done in the same cycle as timeout: proc_done wins.
  - Counter cleared on PROC entry.
- WRITE: when dacfifo_full=0, dacfifo_write=1 for one cycle with dacfifo_writedata = result -> IDLE.
  - When dacfifo_full=1, stall in WRITE holding result. No RX read while stalled.
- bypass is sampled only in CAPTURE; a change mid-sample takes effect on the next sample.
- enable deasserted in any non-IDLE state does not abort; the sample completes, then the FSM stays in IDLE.
- Latency, bypass, FIFOs not full: RX read pulse to TX write pulse = 2 cycles. Minimum period 4 cycles per sample.
- Processed: read to write = 3 + (cycles from proc_start to proc_done) cycles.
- adcfifo_read and dacfifo_write are never high in the same cycle. proc_start is never reissued before done or timeout.
- proc_done seen outside PROC is ignored.

Optional Feature:
- Macro: AUDIO_SEQ_STATS_EN.
- Defined: adds outputs sample_cnt [CNT_WIDTH-1:0] and timeout_cnt [CNT_WIDTH-1:0], plus stall_cnt [CNT_WIDTH-1:0].
  - sample_cnt increments on each dacfifo_write.
  - timeout_cnt increments on each timeout.
  - stall_cnt increments on each cycle in WRITE with dacfifo_full=1.
  - All counters saturate at all-ones and reset to 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package audio_seq_pkg holds:
  - state encoding localparams (ST_IDLE=0, ST_READ=1, ST_CAPTURE=2, ST_PROC=3, ST_WRITE=4, 3-bit);
  - default DATA_WIDTH and the channel slice constants LEFT_LSB=0, RIGHT_LSB=16.
- One natural sub-module, seq_timeout_counter: clear, enable and terminal-count flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Bypass=1, RX FIFO holds 0x1234_ABCD, TX not full -> adcfifo_read at cycle N, dacfifo_write at cycle N+2 with 0x1234_ABCD; busy high N..N+2.
- Bypass=0, proc_data 0x0001_0002; model returns proc_done 5 cycles after proc_start with 0x0002_0004 -> TX write of 0x0002_0004; timeout_err stays 0.
- Bypass=0, proc_done never returned, TIMEOUT_CYCLES=8 -> write of the raw sample after timeout; timeout_err=1 and remains set; the next sample proceeds normally.
- TX full held 10 cycles while in WRITE -> no write and no RX read during the stall; a single write when full drops; with AUDIO_SEQ_STATS_EN, stall_cnt=10.
- enable dropped the cycle after adcfifo_read -> that sample is still written; no further reads while enable=0 and the RX FIFO is non-empty.
- reset_n pulsed low during PROC -> all outputs 0 immediately; a late proc_done after release is ignored; no write occurs.
